decode_timing: RTL and testbench
================================

Name: decode_timing

Overview:
- Parametrised instruction-timing sequencer, successor to the fixed 7-state timing logic inside the CPU decoder.
- Owns the one-hot T-state counter, the instruction register, SYNC and the READY stall.
- Adds what the earlier logic lacked: variable T-state depth, a READY stall on read cycles, NMI edge capture, IRQ masking, a forced-BRK interrupt/reset sequence and a T-overflow error pulse.
- Sits between the data-in latch and the combinational decode/control-generation logic. That logic returns o_tlast/tskip via i_tlast/i_tskip.

Parameters:
T_STATES, 7, number of one-hot T-state bits (min 3).
IR_W, 8, instruction register / opcode width.
BRK_OP, 8'h00, opcode forced into IR for interrupt and reset sequences (width IR_W).

Ports:
i_clk  input  1  system clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
i_din  input  IR_W  data bus in; opcode byte during the SYNC cycle.
i_ready  input  1  READY; low stalls the sequencer on read cycles.
i_rw  input  1  current bus cycle direction, 1 = read.
i_tlast  input  T_STATES  one-hot final T-state of the current instruction, from decode.
i_tskip  input  1  advance by two T-states instead of one.
i_nmi  input  1  NMI request, rising-edge sensitive, active high.
i_irq  input  1  IRQ request, level sensitive, active high.
i_irq_mask  input  1  I flag; 1 masks IRQ.
o_t  output  T_STATES  one-hot current T-state.
o_ir  output  IR_W  latched instruction register.
o_op  output  IR_W  opcode for decode (combinational, see below).
o_sync  output  1  opcode-fetch cycle indicator.
o_int_seq  output  1  current instruction is a forced interrupt/reset sequence.
o_int_vec  output  2  vector select: 0 IRQ, 1 NMI, 2 RESET, 3 unused.
o_t_err  output  1  one-cycle pulse on T-state overflow.

Behaviour:
- Reset (async, i_rst_n low) forces:
  - o_t = 1<<1 (T1), o_ir = BRK_OP, o_sync = 0, o_int_seq = 1, o_int_vec = 2, o_t_err = 0.
  - NMI pending flag = 0; registered NMI sample = 0.
  - Reset release therefore runs the BRK sequence with the RESET vector from T1.
  - Reset asserted mid-instruction aborts it immediately to these values.
- Advance condition: adv = i_ready | ~i_rw.
  - A read cycle with i_ready low holds o_t, o_ir, o_sync, o_int_seq and o_int_vec.
  - Write cycles always advance.
- On adv, exactly one of the following, in priority order:
  - o_t == i_tlast (exact match): o_t <= 1 (T0), o_sync <= 1.
  - Shift would pass the MSB (o_t[T_STATES-1] set, or i_tskip with o_t[T_STATES-2] set): o_t <= 1, o_sync <= 1, o_t_err <= 1 for one cycle.
  - i_tskip: o_t <= o_t << 2.
  - Otherwise: o_t <= o_t << 1.
  - o_sync deasserts on any adv from a cycle where it was 1 (unless the match/overflow rules above reassert it).
- Fetch: on adv while o_sync = 1, take = nmi_pend | (i_irq & ~i_irq_mask).
  - take = 1: o_ir <= BRK_OP, o_int_seq <= 1, o_int_vec <= nmi_pend ? 1 : 0. NMI has priority; nmi_pend clears.
  - take = 0: o_ir <= i_din, o_int_seq <= 0, o_int_vec <= 0.
- o_op = o_sync ? (take ? BRK_OP : i_din) : o_ir, so decode sees the correct opcode in the SYNC cycle.
- NMI capture:
  - A registered i_nmi is sampled every cycle regardless of stall; a rising edge sets nmi_pend.
  - An edge coinciding with a taking fetch stays pending for the next fetch.
  - nmi_pend is never lost during a stall.
- IRQ: level sampled only at the fetch cycle. Deassertion before fetch means no interrupt; no latching.
- o_t is always exactly one-hot; no other state is reachable.

Test Plan:
- Reset release, i_tlast = T4, i_ready = 1 -> o_t steps T1,T2,T3,T4, then o_t = 1 and o_sync = 1 on the 4th edge; o_int_vec = 2 and o_ir = 8'h00 throughout.
- SYNC with i_din = 8'hA9, i_tlast = T1 -> o_op = 8'hA9 combinationally; after the edge o_ir = 8'hA9, o_t = 2'b10, o_int_seq = 0; the next edge returns to T0 with sync.
- i_ready = 0, i_rw = 1 for 3 cycles at T2 -> o_t holds T2; switching i_rw = 0 with i_ready still 0 -> advances to T3.
- i_tskip = 1 at T2, i_tlast = T6 -> o_t = T4; with T_STATES = 7, skip from T5 -> o_t = 1, o_sync = 1, single o_t_err pulse.
- NMI pulse mid-instruction with i_irq = 1, i_irq_mask = 0 -> next fetch loads BRK_OP with o_int_vec = 1; the following fetch takes IRQ with o_int_vec = 0; with i_irq_mask = 1 the opcode from i_din is loaded instead.
- Assert i_rst_n low asynchronously at T3 -> all outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/decode_timing.sv
// rtl/decode_timing.sv - instruction timing sequencer: one-hot T-state, IR, SYNC, READY stall, interrupts
module decode_timing #(
    parameter int T_STATES = 7,
    parameter int IR_W = 8,
    parameter logic [IR_W-1:0] BRK_OP = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [IR_W-1:0]     i_din,
    input  logic                i_ready,
    input  logic                i_rw,
    input  logic [T_STATES-1:0] i_tlast,
    input  logic                i_tskip,
    input  logic                i_nmi,
    input  logic                i_irq,
    input  logic                i_irq_mask,
    output logic [T_STATES-1:0] o_t,
    output logic [IR_W-1:0]     o_ir,
    output logic [IR_W-1:0]     o_op,
    output logic                o_sync,
    output logic                o_int_seq,
    output logic [1:0]          o_int_vec,
    output logic                o_t_err
);

    localparam logic [T_STATES-1:0] T0 = T_STATES'(1);
    localparam logic [T_STATES-1:0] T1 = T_STATES'(2);

    logic                nmi_q;
    logic                nmi_pend;
    logic                adv;
    logic                take;
    logic                fetch;
    logic                overflow;
    logic [T_STATES-1:0] t_next;
    logic [IR_W-1:0]     ir_next;
    logic                sync_next;
    logic                int_seq_next;
    logic [1:0]          int_vec_next;
    logic                t_err_next;
    logic                nmi_pend_next;

    assign adv      = i_ready | ~i_rw;
    assign take     = nmi_pend | (i_irq & ~i_irq_mask);
    assign fetch    = adv & o_sync;
    assign overflow = o_t[T_STATES-1] | (i_tskip & o_t[T_STATES-2]);
    assign o_op     = o_sync ? (take ? BRK_OP : i_din) : o_ir;

    always_comb begin
        t_next       = o_t;
        sync_next    = o_sync;
        t_err_next   = 1'b0;
        ir_next      = o_ir;
        int_seq_next = o_int_seq;
        int_vec_next = o_int_vec;
        if (adv) begin
            sync_next = 1'b0;
            if (o_t == i_tlast) begin
                t_next    = T0;
                sync_next = 1'b1;
            end else if (overflow) begin
                t_next     = T0;
                sync_next  = 1'b1;
                t_err_next = 1'b1;
            end else if (i_tskip) begin
                t_next = o_t << 2;
            end else begin
                t_next = o_t << 1;
            end
        end
        if (fetch) begin
            if (take) begin
                ir_next      = BRK_OP;
                int_seq_next = 1'b1;
                int_vec_next = nmi_pend ? 2'd1 : 2'd0;
            end else begin
                ir_next      = i_din;
                int_seq_next = 1'b0;
                int_vec_next = 2'd0;
            end
        end
        // a fresh edge arriving on the fetch that consumes nmi_pend stays pending
        nmi_pend_next = (nmi_pend & ~fetch) | (i_nmi & ~nmi_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_t       <= T1;
            o_ir      <= BRK_OP;
            o_sync    <= 1'b0;
            o_int_seq <= 1'b1;
            o_int_vec <= 2'd2;
            o_t_err   <= 1'b0;
            nmi_q     <= 1'b0;
            nmi_pend  <= 1'b0;
        end else begin
            o_t       <= t_next;
            o_ir      <= ir_next;
            o_sync    <= sync_next;
            o_int_seq <= int_seq_next;
            o_int_vec <= int_vec_next;
            o_t_err   <= t_err_next;
            nmi_q     <= i_nmi;
            nmi_pend  <= nmi_pend_next;
        end
    end

endmodule

// File: tb/tb_decode_timing.sv
// tb/tb_decode_timing.sv - directed self-checking bench for decode_timing
module tb_decode_timing;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       ready;
    logic       rw;
    logic [6:0] tlast;
    logic       tskip;
    logic       nmi;
    logic       irq;
    logic       irq_mask;
    logic [6:0] t;
    logic [7:0] ir;
    logic [7:0] op;
    logic       sync;
    logic       int_seq;
    logic [1:0] int_vec;
    logic       t_err;

    int n_checks = 0;
    int n_fail = 0;

    decode_timing #(.T_STATES(7), .IR_W(8), .BRK_OP(8'h00)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_din      (din),
        .i_ready    (ready),
        .i_rw       (rw),
        .i_tlast    (tlast),
        .i_tskip    (tskip),
        .i_nmi      (nmi),
        .i_irq      (irq),
        .i_irq_mask (irq_mask),
        .o_t        (t),
        .o_ir       (ir),
        .o_op       (op),
        .o_sync     (sync),
        .o_int_seq  (int_seq),
        .o_int_vec  (int_vec),
        .o_t_err    (t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_t"}, 32'(t), 32'h02);
        check({tag, "_ir"}, 32'(ir), 32'h00);
        check({tag, "_sync"}, 32'(sync), 32'h0);
        check({tag, "_int_seq"}, 32'(int_seq), 32'h1);
        check({tag, "_int_vec"}, 32'(int_vec), 32'h2);
        check({tag, "_t_err"}, 32'(t_err), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; din = 8'h00; ready = 1'b1; rw = 1'b1;
        tlast = 7'b0010000; tskip = 1'b0; nmi = 1'b0; irq = 1'b0; irq_mask = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;

        // BRK/RESET sequence from T1 to T4
        step(); check("seq_t2", 32'(t), 32'h04);
        step(); check("seq_t3", 32'(t), 32'h08);
        step(); check("seq_t4", 32'(t), 32'h10);
        check("seq_vec", 32'(int_vec), 32'h2);
        check("seq_ir", 32'(ir), 32'h00);
        step(); check("seq_t0", 32'(t), 32'h01);
        check("seq_sync", 32'(sync), 32'h1);

        // opcode fetch, two-cycle instruction
        din = 8'hA9; tlast = 7'b0000010; #1;
        check("op_sync", 32'(op), 32'hA9);
        step();
        check("fetch_ir", 32'(ir), 32'hA9);
        check("fetch_t", 32'(t), 32'h02);
        check("fetch_int_seq", 32'(int_seq), 32'h0);
        check("fetch_sync", 32'(sync), 32'h0);
        check("op_ir", 32'(op), 32'hA9);
        step();
        check("short_t0", 32'(t), 32'h01);
        check("short_sync", 32'(sync), 32'h1);

        // READY stall on reads, writes advance
        tlast = 7'b1000000; din = 8'h20;
        step(); check("st_t1", 32'(t), 32'h02);
        step(); check("st_t2", 32'(t), 32'h04);
        ready = 1'b0; rw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", 32'(t), 32'h04);
        end
        check("stall_ir", 32'(ir), 32'h20);
        rw = 1'b0;
        step(); check("write_adv", 32'(t), 32'h08);
        ready = 1'b1; rw = 1'b1;
        tlast = 7'b0001000;
        step(); check("st_end", 32'(t), 32'h01);

        // skip and overflow
        tlast = 7'b1000000;
        step(); check("sk_t1", 32'(t), 32'h02);
        step(); check("sk_t2", 32'(t), 32'h04);
        tskip = 1'b1;
        step(); check("skip_t4", 32'(t), 32'h10);
        tskip = 1'b0;
        step(); check("sk_t5", 32'(t), 32'h20);
        tskip = 1'b1;
        step();
        check("ovf_t", 32'(t), 32'h01);
        check("ovf_sync", 32'(sync), 32'h1);
        check("ovf_err", 32'(t_err), 32'h1);
        tskip = 1'b0;
        step();
        check("ovf_err_pulse", 32'(t_err), 32'h0);
        check("ovf_next_t", 32'(t), 32'h02);

        // NMI mid-instruction beats pending IRQ
        tlast = 7'b0001000;
        nmi = 1'b1;
        step(); check("nmi_t2", 32'(t), 32'h04);
        nmi = 1'b0; irq = 1'b1; irq_mask = 1'b0; din = 8'h55;
        step(); check("nmi_t3", 32'(t), 32'h08);
        step(); check("nmi_sync", 32'(sync), 32'h1);
        check("nmi_op", 32'(op), 32'h00);
        step();
        check("nmi_ir", 32'(ir), 32'h00);
        check("nmi_vec", 32'(int_vec), 32'h1);
        check("nmi_int_seq", 32'(int_seq), 32'h1);
        repeat (3) step();
        check("irq_sync", 32'(sync), 32'h1);
        step();
        check("irq_vec", 32'(int_vec), 32'h0);
        check("irq_int_seq", 32'(int_seq), 32'h1);
        check("irq_ir", 32'(ir), 32'h00);
        irq_mask = 1'b1; din = 8'hEA;
        repeat (3) step();
        check("mask_op", 32'(op), 32'hEA);
        step();
        check("mask_ir", 32'(ir), 32'hEA);
        check("mask_int_seq", 32'(int_seq), 32'h0);
        check("mask_vec", 32'(int_vec), 32'h0);

        // asynchronous reset at T3
        step(); step();
        check("pre_rst_t3", 32'(t), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst");
        check("arst_op", 32'(op), 32'h00);
        step();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
